// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through data cache responder with backing-memory req/ack
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wd,
    output logic [DATA_WIDTH-1:0]    cpu_rd,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR, RESP} state_t;

    state_t                     state_q, state_d;
    logic [LINES-1:0]           valid_q;
    logic [TAG_W-1:0]           tag_q  [LINES];
    logic [DATA_WIDTH-1:0]      data_q [LINES];
    logic [ADDRESS_WIDTH-3:0]   addr_q;
    logic [DATA_WIDTH-1:0]      wd_q;

    logic [INDEX_BITS-1:0]      cpu_idx, lat_idx;
    logic [TAG_W-1:0]           cpu_tag, lat_tag;
    logic                       hit, lat_hit;
    logic                       latch_en, refill, wr_update, rd_hit, rd_miss_start;
    logic                       unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign cpu_idx = cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag = cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign lat_idx = addr_q[INDEX_BITS-1:0];
    assign lat_tag = addr_q[ADDRESS_WIDTH-3:INDEX_BITS];

    assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    assign cpu_rd  = data_q[cpu_idx];

    // Memory-side outputs come only from state and the latched request.
    assign mem_req  = (state_q == RD_MISS) || (state_q == WR);
    assign mem_we   = (state_q == WR);
    assign mem_addr = {addr_q, 2'b00};
    assign mem_wd   = wd_q;

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        latch_en      = 1'b0;
        refill        = 1'b0;
        wr_update     = 1'b0;
        rd_hit        = 1'b0;
        rd_miss_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    stall    = 1'b1;
                    latch_en = 1'b1;
                    state_d  = WR;
                end else if (cpu_re && !hit) begin
                    stall         = 1'b1;
                    latch_en      = 1'b1;
                    rd_miss_start = 1'b1;
                    state_d       = RD_MISS;
                end else if (cpu_re) begin
                    rd_hit = 1'b1;
                end
            end
            RD_MISS: begin
                stall = 1'b1;
                if (mem_ack) begin
                    refill  = 1'b1;
                    state_d = RESP;
                end
            end
            WR: begin
                stall = 1'b1;
                if (mem_ack) begin
                    wr_update = lat_hit;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q <= cpu_addr[ADDRESS_WIDTH-1:2];
            end
            if (latch_en && cpu_we) begin
                wd_q <= cpu_wd;
            end
            if (refill) begin
                valid_q[lat_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refill) begin
                tag_q[lat_idx]  <= lat_tag;
                data_q[lat_idx] <= mem_rd;
            end else if (wr_update) begin
                data_q[lat_idx] <= wd_q;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q, hit_d, miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (rd_hit && hit_q != 16'hFFFF) begin
            hit_d = hit_q + 16'd1;
        end
        if (rd_miss_start && miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule
